// File: rtl/beta_pkg.sv
// Shared types and defaults for the Bourbon core memory-bus arbiter.
package beta_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_IFS,
    OWN_EXES
  } arb_owner_e;

  localparam int ARB_STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/beta_mem_arbiter.sv
// Shares one single-ported memory bus between fetch (ifs) and execute (exes),
// one outstanding transaction, exes priority with a fetch starvation guard.
module beta_mem_arbiter
  import beta_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int StarveMax = ARB_STARVE_MAX_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ifs_req_i,
  input  logic [AddrWidth-1:0]   ifs_addr_i,
  output logic                   ifs_gnt_o,
  output logic                   ifs_rvalid_o,
  output logic [DataWidth-1:0]   ifs_rdata_o,
  input  logic                   exes_req_i,
  input  logic                   exes_we_i,
  input  logic [DataWidth/8-1:0] exes_be_i,
  input  logic [AddrWidth-1:0]   exes_addr_i,
  input  logic [DataWidth-1:0]   exes_wdata_i,
  output logic                   exes_gnt_o,
  output logic                   exes_rvalid_o,
  output logic [DataWidth-1:0]   exes_rdata_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  output logic                   arb_busy_o
);

  localparam int BeWidth  = DataWidth / 8;
  localparam int CntWidth = $clog2(StarveMax + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(StarveMax);

  arb_state_e             state_q;
  arb_owner_e             owner_q;
  logic [CntWidth-1:0]    starve_q;
  logic                   we_q;
  logic [BeWidth-1:0]     be_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   wdata_q;

  logic arb_en;
  logic any_req;
  logic exes_win;
  logic ifs_win;

  // Handshake: a requester holds req (and its payload) until it sees gnt in the
  // same cycle; gnt is only issued in ARB_IDLE. The response arrives later as a
  // single-cycle rvalid to the owner, mirroring mem_rvalid_i in ARB_RESP.
  assign arb_en   = (state_q == ARB_IDLE) && !rst_i;
  assign any_req  = ifs_req_i || exes_req_i;
  assign exes_win = exes_req_i && ((starve_q < CntMax) || !ifs_req_i);
  assign ifs_win  = ifs_req_i && !exes_win;

  assign exes_gnt_o = arb_en && exes_win;
  assign ifs_gnt_o  = arb_en && ifs_win;

  assign ifs_rvalid_o  = (state_q == ARB_RESP) && (owner_q == OWN_IFS)  && mem_rvalid_i && !rst_i;
  assign exes_rvalid_o = (state_q == ARB_RESP) && (owner_q == OWN_EXES) && mem_rvalid_i && !rst_i;
  assign ifs_rdata_o   = mem_rdata_i;
  assign exes_rdata_o  = mem_rdata_i;

  assign mem_req_o   = (state_q == ARB_REQ);
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign arb_busy_o  = (state_q != ARB_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IFS;
      starve_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            state_q <= ARB_REQ;
            if (exes_win) begin
              owner_q <= OWN_EXES;
              we_q    <= exes_we_i;
              be_q    <= exes_be_i;
              addr_q  <= exes_addr_i;
              wdata_q <= exes_wdata_i;
            end else begin
              owner_q <= OWN_IFS;
              we_q    <= 1'b0;
              be_q    <= '1;
              addr_q  <= ifs_addr_i;
              wdata_q <= '0;
            end
            // Counts exes grants that bypassed a waiting fetch.
            if (!ifs_req_i || ifs_win) begin
              starve_q <= '0;
            end else if (starve_q != CntMax) begin
              starve_q <= starve_q + CntWidth'(1);
            end
          end
        end
        ARB_REQ: begin
          if (mem_gnt_i) state_q <= ARB_RESP;
        end
        ARB_RESP: begin
          if (mem_rvalid_i) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beta_mem_arbiter.sv
// Self-checking bench for beta_mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_beta_mem_arbiter;
  import beta_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;
  localparam int SM = 4;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic          ifs_req_i;
  logic [AW-1:0] ifs_addr_i;
  logic          ifs_gnt_o, ifs_rvalid_o;
  logic [DW-1:0] ifs_rdata_o;
  logic          exes_req_i, exes_we_i;
  logic [BW-1:0] exes_be_i;
  logic [AW-1:0] exes_addr_i;
  logic [DW-1:0] exes_wdata_i;
  logic          exes_gnt_o, exes_rvalid_o;
  logic [DW-1:0] exes_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i, mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  logic          arb_busy_o;

  beta_mem_arbiter #(.DataWidth(DW), .AddrWidth(AW), .StarveMax(SM)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifs_req_i(ifs_req_i), .ifs_addr_i(ifs_addr_i), .ifs_gnt_o(ifs_gnt_o),
    .ifs_rvalid_o(ifs_rvalid_o), .ifs_rdata_o(ifs_rdata_o),
    .exes_req_i(exes_req_i), .exes_we_i(exes_we_i), .exes_be_i(exes_be_i),
    .exes_addr_i(exes_addr_i), .exes_wdata_i(exes_wdata_i), .exes_gnt_o(exes_gnt_o),
    .exes_rvalid_o(exes_rvalid_o), .exes_rdata_o(exes_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .arb_busy_o(arb_busy_o)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // transaction-level reference model
  logic          m_busy, m_acc, m_exes, m_we;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_starve;
  logic [DW-1:0] exp_q[$];
  bit            sb_on;
  logic          last_ifs_gnt, last_exes_gnt;
  int            glog[$];
  int            rv_ifs, rv_exes;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  // One cycle: inputs already driven at posedge+1; check at negedge, advance model.
  task automatic step();
    logic e_exes_win, e_arb, e_resp;
    #4;
    e_exes_win = exes_req_i && ((m_starve < SM) || !ifs_req_i);
    e_arb      = !m_busy && !rst_i;
    e_resp     = m_busy && m_acc && mem_rvalid_i && !rst_i;
    last_exes_gnt = e_arb && e_exes_win;
    last_ifs_gnt  = e_arb && ifs_req_i && !e_exes_win;

    check_eq("arb_busy",    arb_busy_o,    m_busy);
    check_eq("mem_req",     mem_req_o,     m_busy && !m_acc);
    check_eq("exes_gnt",    exes_gnt_o,    last_exes_gnt);
    check_eq("ifs_gnt",     ifs_gnt_o,     last_ifs_gnt);
    check_eq("exes_rvalid", exes_rvalid_o, e_resp && m_exes);
    check_eq("ifs_rvalid",  ifs_rvalid_o,  e_resp && !m_exes);
    check_eq("mem_addr",    mem_addr_o,    m_addr);
    check_eq("mem_we",      mem_we_o,      m_we);
    check_eq("mem_be",      mem_be_o,      m_be);
    check_eq("mem_wdata",   mem_wdata_o,   m_wdata);
    check_eq("ifs_rdata",   ifs_rdata_o,   mem_rdata_i);
    check_eq("exes_rdata",  exes_rdata_o,  mem_rdata_i);

    if (exes_gnt_o) glog.push_back(1);
    if (ifs_gnt_o)  glog.push_back(0);
    if (ifs_rvalid_o)  rv_ifs++;
    if (exes_rvalid_o) rv_exes++;

    if (sb_on && e_resp && !m_we) begin
      check_eq("sb_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0)
        check_eq("sb_rdata", m_exes ? exes_rdata_o : ifs_rdata_o, exp_q.pop_front());
    end

    if (rst_i) begin
      m_busy = 0; m_acc = 0; m_exes = 0; m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
      m_starve = 0;
      exp_q.delete();
    end else if (e_arb && (ifs_req_i || exes_req_i)) begin
      m_busy = 1; m_acc = 0; m_exes = e_exes_win;
      if (e_exes_win) begin
        m_we = exes_we_i; m_be = exes_be_i; m_addr = exes_addr_i; m_wdata = exes_wdata_i;
        m_starve = ifs_req_i ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
      end else begin
        m_we = 0; m_be = '1; m_addr = ifs_addr_i; m_wdata = '0;
        m_starve = 0;
      end
      if (sb_on && !m_we) exp_q.push_back(mem_f(m_addr));
    end else if (m_busy && !m_acc && mem_gnt_i) begin
      m_acc = 1;
    end else if (e_resp) begin
      m_busy = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  // driver tasks
  task automatic idle_inputs();
    rst_i = 0; ifs_req_i = 0; ifs_addr_i = '0;
    exes_req_i = 0; exes_we_i = 0; exes_be_i = '0; exes_addr_i = '0; exes_wdata_i = '0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  task automatic cyc();
    step();
    if (last_ifs_gnt)  ifs_req_i = 0;
    if (last_exes_gnt) exes_req_i = 0;
  endtask

  task automatic clear_logs();
    glog.delete(); rv_ifs = 0; rv_exes = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    step(); step();
    rst_i = 0;
  endtask

  int n_exes_first;

  initial begin
    m_busy = 0; m_acc = 0; m_exes = 0; m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
    m_starve = 0; sb_on = 0; last_ifs_gnt = 0; last_exes_gnt = 0;
    idle_inputs();
    rst_i = 1;
    @(posedge clk_i); #1;
    do_reset();
    check_eq("rst_starve", 64'(dut.starve_q), 0);
    check_eq("rst_busy", arb_busy_o, 0);

    // single fetch
    clear_logs();
    mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
    ifs_req_i = 1; ifs_addr_i = 32'h100;
    repeat (4) cyc();
    check_eq("fetch_rv_ifs", rv_ifs, 1);
    check_eq("fetch_rv_exes", rv_exes, 0);

    // simultaneous requests: exes first, then ifs
    clear_logs();
    ifs_req_i = 1; ifs_addr_i = 32'h140;
    exes_req_i = 1; exes_addr_i = 32'h1000; exes_we_i = 0; exes_be_i = 4'hF;
    repeat (8) cyc();
    check_eq("simul_ngnt", glog.size(), 2);
    check_eq("simul_first_exes", (glog.size() > 0) ? glog[0] : -1, 1);
    check_eq("simul_then_ifs", (glog.size() > 1) ? glog[1] : -1, 0);

    // starvation guard
    do_reset();
    clear_logs();
    mem_gnt_i = 1; mem_rvalid_i = 1;
    ifs_req_i = 1; ifs_addr_i = 32'h200;
    exes_req_i = 1; exes_addr_i = 32'h2200;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_ifs_gnt) break;
    end
    ifs_req_i = 0; exes_req_i = 0;
    n_exes_first = 0;
    foreach (glog[i]) begin
      if (glog[i] == 0) break;
      n_exes_first++;
    end
    check_eq("starve_exes_grants", n_exes_first, SM);
    check_eq("starve_ifs_granted", glog.size(), SM + 1);
    check_eq("starve_cnt_after", 64'(dut.starve_q), 0);
    repeat (4) cyc();

    // backpressure
    do_reset();
    clear_logs();
    exes_req_i = 1; exes_addr_i = 32'h3000; exes_we_i = 1; exes_be_i = 4'b1100;
    exes_wdata_i = 32'hCAFE_0001;
    cyc();
    ifs_req_i = 1; ifs_addr_i = 32'h300; exes_req_i = 1; exes_addr_i = 32'h3300;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bp_req", mem_req_o, 1);
      check_eq("bp_addr", mem_addr_o, 32'h3000);
      check_eq("bp_wdata", mem_wdata_o, 32'hCAFE_0001);
      check_eq("bp_be", mem_be_o, 4'b1100);
      check_eq("bp_busy", arb_busy_o, 1);
    end
    check_eq("bp_no_gnt", glog.size(), 1);
    ifs_req_i = 0; exes_req_i = 0;
    mem_gnt_i = 1; mem_rvalid_i = 1;
    repeat (4) cyc();

    // store
    clear_logs();
    exes_req_i = 1; exes_we_i = 1; exes_be_i = 4'b0011; exes_addr_i = 32'h2000;
    exes_wdata_i = 32'h1234_5678;
    repeat (5) cyc();
    check_eq("store_rv_once", rv_exes, 1);
    check_eq("store_rv_ifs", rv_ifs, 0);

    // reset during ARB_RESP
    clear_logs();
    mem_gnt_i = 1; mem_rvalid_i = 0;
    ifs_req_i = 1; ifs_addr_i = 32'h400;
    cyc(); cyc();
    rst_i = 1; cyc();
    rst_i = 0; mem_rvalid_i = 1; cyc();
    check_eq("rstmid_rv", rv_ifs + rv_exes, 0);
    check_eq("rstmid_busy", arb_busy_o, 0);
    ifs_req_i = 1; ifs_addr_i = 32'h500;
    repeat (4) cyc();
    check_eq("rstmid_next_served", rv_ifs, 1);

    // randomized traffic with scoreboard
    do_reset();
    sb_on = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!ifs_req_i || last_ifs_gnt) begin
        ifs_req_i  = ($urandom_range(0, 2) == 0);
        ifs_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!exes_req_i || last_exes_gnt) begin
        exes_req_i   = ($urandom_range(0, 1) == 0);
        exes_we_i    = $urandom_range(0, 1);
        exes_be_i    = BW'($urandom_range(0, 15));
        exes_addr_i  = $urandom;
        exes_wdata_i = $urandom;
      end
      mem_gnt_i    = ($urandom_range(0, 2) != 0);
      mem_rvalid_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i  = mem_f(mem_addr_o);
      rst_i        = ($urandom_range(0, 199) == 0);
      step();
    end
    rst_i = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
